// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch controller: FSM states, widths and
// the {pc, inst} entry that is buffered between ROM and decode.
package fetch_pkg;

  localparam int PC_W       = 64;
  localparam int INST_W     = 32;
  localparam int INST_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    FAULT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_ctrl_if.sv
// Bundle of the ROM, redirect, decode and perf signals of the fetch controller.
// The master modport is the fetch controller's view, slave is the environment's.
interface inst_fetch_ctrl_if;

  logic                          rom_ce;
  logic [fetch_pkg::PC_W-1:0]    rom_addr;
  logic                          rom_valid;
  logic [fetch_pkg::INST_W-1:0]  rom_inst;
  logic                          redirect;
  logic [fetch_pkg::PC_W-1:0]    redirect_pc;
  logic                          id_valid;
  logic                          id_ready;
  logic [fetch_pkg::PC_W-1:0]    id_pc;
  logic [fetch_pkg::INST_W-1:0]  id_inst;
  logic                          fetch_fault;
  logic [31:0]                   perf_fetched;
  logic [31:0]                   perf_wait;

  modport master (
    output rom_ce, rom_addr, id_valid, id_pc, id_inst, fetch_fault,
           perf_fetched, perf_wait,
    input  rom_valid, rom_inst, redirect, redirect_pc, id_ready
  );

  modport slave (
    input  rom_ce, rom_addr, id_valid, id_pc, id_inst, fetch_fault,
           perf_fetched, perf_wait,
    output rom_valid, rom_inst, redirect, redirect_pc, id_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries; flush (and rst) empty it and win over
// push/pop. The head reads as zero while the FIFO is empty.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_flush,
  input  logic                   i_push,
  input  fetch_entry_t           i_push_data,
  input  logic                   i_pop,
  output logic [$clog2(DEPTH):0] o_count,
  output fetch_entry_t           o_head,
  output logic                   o_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

  fetch_entry_t  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign o_empty = (r_count == '0);
  assign w_push  = i_push && (r_count != FULL_CNT);
  assign w_pop   = i_pop && !o_empty;
  assign o_count = r_count;
  assign o_head  = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + {{PW{1'b0}}, w_push} - {{PW{1'b0}}, w_pop};
    end
  end

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch controller: owns the PC, requests words from the ROM,
// buffers {pc, inst} for decode and handles redirects. FETCH_PERF_CNT_EN adds perf counters.
module inst_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  inst_fetch_ctrl_if.master io_bus
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_CNT = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] LAST_CNT  = CW'(FIFO_DEPTH - 1);

  fetch_state_e    r_state;
  fetch_state_e    w_next_state;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_next_pc;
  logic            r_fault;
  logic            w_next_fault;
  logic            w_push;
  logic            w_pop;
  logic            w_flush;
  logic            w_empty;
  logic [CW-1:0]   w_count;
  logic [CW-1:0]   w_count_pop;
  fetch_entry_t    w_push_entry;
  fetch_entry_t    w_head;

  assign w_pop        = !w_empty && io_bus.id_ready;
  assign w_count_pop  = w_count - {{(CW-1){1'b0}}, w_pop};
  assign w_push_entry = '{pc: r_pc, inst: io_bus.rom_inst};

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_flush    (w_flush),
    .i_push     (w_push),
    .i_push_data(w_push_entry),
    .i_pop      (w_pop),
    .o_count    (w_count),
    .o_head     (w_head),
    .o_empty    (w_empty)
  );

  // Occupancy decisions use the post-pop count so a freed slot restarts fetch at once.
  always_comb begin
    w_next_state = r_state;
    w_next_pc    = r_pc;
    w_next_fault = r_fault;
    w_push       = 1'b0;
    w_flush      = 1'b0;
    if (io_bus.redirect) begin
      w_flush   = 1'b1;
      w_next_pc = io_bus.redirect_pc;
      if (io_bus.redirect_pc[1:0] == 2'b00) begin
        w_next_state = REQ;
        w_next_fault = 1'b0;
      end else begin
        w_next_state = FAULT;
        w_next_fault = 1'b1;
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (w_count_pop < DEPTH_CNT) w_next_state = REQ;
        end
        REQ: begin
          if (io_bus.rom_valid) begin
            w_push    = 1'b1;
            w_next_pc = r_pc + PC_W'(INST_BYTES);
            if (w_count_pop >= LAST_CNT) w_next_state = IDLE;
          end
        end
        FAULT:   w_next_state = FAULT;
        default: w_next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_pc    <= RESET_PC;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_pc    <= w_next_pc;
      r_fault <= w_next_fault;
    end
  end

  assign io_bus.rom_ce      = (r_state == REQ);
  assign io_bus.rom_addr    = r_pc;
  assign io_bus.id_valid    = !w_empty;
  assign io_bus.id_pc       = w_head.pc;
  assign io_bus.id_inst     = w_head.inst;
  assign io_bus.fetch_fault = r_fault;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_wait;

  // Redirects leave the counters alone; only rst clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_fetched <= '0;
      r_perf_wait    <= '0;
    end else begin
      if (w_push) r_perf_fetched <= r_perf_fetched + 32'd1;
      if ((r_state == REQ) && !io_bus.rom_valid) r_perf_wait <= r_perf_wait + 32'd1;
    end
  end

  assign io_bus.perf_fetched = r_perf_fetched;
  assign io_bus.perf_wait    = r_perf_wait;
`else
  assign io_bus.perf_fetched = '0;
  assign io_bus.perf_wait    = '0;
`endif

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed self-checking bench for inst_fetch_ctrl with a hand-driven ROM.
// Perf counter checks are compiled in when FETCH_PERF_CNT_EN is defined.
module tb_inst_fetch_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  inst_fetch_ctrl_if bus ();

  inst_fetch_ctrl #(
    .RESET_PC  (64'h0),
    .FIFO_DEPTH(4)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .io_bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] romWord(input logic [63:0] addr);
    return addr[31:0] ^ 32'h5A5A_0013;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      $error("[TB] check %s did not match", tag);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [31:0] inst,
                               input logic redir, input logic [63:0] rpc,
                               input logic ready);
    bus.rom_valid   = valid;
    bus.rom_inst    = inst;
    bus.redirect    = redir;
    bus.redirect_pc = rpc;
    bus.id_ready    = ready;
  endtask

  task automatic applyReset();
    rst = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 64'h0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Holds the ROM response for 'waits' cycles, then pulses rom_valid with the word for addr.
  task automatic fetchOne(input logic [63:0] addr, input int waits);
    for (int i = 0; i < waits; i++) begin
      checkOutput("wait_ce", {63'h0, bus.rom_ce}, 64'h1);
      checkOutput("wait_addr", bus.rom_addr, addr);
      bus.rom_valid = 1'b0;
      tick();
    end
    checkOutput("resp_ce", {63'h0, bus.rom_ce}, 64'h1);
    checkOutput("resp_addr", bus.rom_addr, addr);
    bus.rom_valid = 1'b1;
    bus.rom_inst  = romWord(addr);
    tick();
    bus.rom_valid = 1'b0;
    bus.rom_inst  = 32'h0;
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 64'h0, 1'b0);
    tick();
    tick();
    $display("[TB] reset values");
    checkOutput("rst_ce", {63'h0, bus.rom_ce}, 64'h0);
    checkOutput("rst_id_valid", {63'h0, bus.id_valid}, 64'h0);
    checkOutput("rst_fault", {63'h0, bus.fetch_fault}, 64'h0);
    checkOutput("rst_id_pc", bus.id_pc, 64'h0);
    checkOutput("rst_id_inst", {32'h0, bus.id_inst}, 64'h0);
    checkOutput("rst_addr", bus.rom_addr, 64'h0);
    checkOutput("rst_perf_fetched", {32'h0, bus.perf_fetched}, 64'h0);
    checkOutput("rst_perf_wait", {32'h0, bus.perf_wait}, 64'h0);

    $display("[TB] free-run fetch, ROM answers every 4th cycle");
    rst = 1'b0;
    bus.id_ready = 1'b1;
    checkOutput("first_cycle_ce", {63'h0, bus.rom_ce}, 64'h0);
    tick();
    for (int k = 0; k < 3; k++) begin
      fetchOne(64'(4 * k), 3);
      checkOutput("run_id_valid", {63'h0, bus.id_valid}, 64'h1);
      checkOutput("run_id_pc", bus.id_pc, 64'(4 * k));
      checkOutput("run_id_inst", {32'h0, bus.id_inst}, {32'h0, romWord(64'(4 * k))});
    end
`ifndef FETCH_PERF_CNT_EN
    checkOutput("perf_fetched_tied", {32'h0, bus.perf_fetched}, 64'h0);
    checkOutput("perf_wait_tied", {32'h0, bus.perf_wait}, 64'h0);
`endif

    $display("[TB] FIFO fills with decode stalled");
    applyReset();
    tick();
    for (int k = 0; k < 4; k++) begin
      fetchOne(64'(4 * k), 0);
    end
    checkOutput("full_ce", {63'h0, bus.rom_ce}, 64'h0);
    checkOutput("full_addr", bus.rom_addr, 64'h10);
    checkOutput("full_id_pc", bus.id_pc, 64'h0);
    checkOutput("full_id_inst", {32'h0, bus.id_inst}, {32'h0, romWord(64'h0)});
    tick();
    tick();
    checkOutput("full_ce_hold", {63'h0, bus.rom_ce}, 64'h0);
    bus.id_ready = 1'b1;
    tick();
    bus.id_ready = 1'b0;
    checkOutput("pop_ce", {63'h0, bus.rom_ce}, 64'h1);
    checkOutput("pop_addr", bus.rom_addr, 64'h10);
    checkOutput("pop_id_pc", bus.id_pc, 64'h4);

    $display("[TB] redirect colliding with rom_valid, 3 entries buffered");
    applyStimulus(1'b1, romWord(64'h10), 1'b1, 64'h100, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 64'h0, 1'b0);
    checkOutput("redir_id_valid", {63'h0, bus.id_valid}, 64'h0);
    checkOutput("redir_ce", {63'h0, bus.rom_ce}, 64'h1);
    checkOutput("redir_addr", bus.rom_addr, 64'h100);
    fetchOne(64'h100, 1);
    checkOutput("redir_first_valid", {63'h0, bus.id_valid}, 64'h1);
    checkOutput("redir_first_pc", bus.id_pc, 64'h100);
    checkOutput("redir_first_inst", {32'h0, bus.id_inst}, {32'h0, romWord(64'h100)});

    $display("[TB] misaligned redirect then recovery");
    applyStimulus(1'b0, 32'h0, 1'b1, 64'h102, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 64'h0, 1'b0);
    checkOutput("fault_set", {63'h0, bus.fetch_fault}, 64'h1);
    checkOutput("fault_ce", {63'h0, bus.rom_ce}, 64'h0);
    checkOutput("fault_id_valid", {63'h0, bus.id_valid}, 64'h0);
    checkOutput("fault_addr", bus.rom_addr, 64'h102);
    for (int i = 0; i < 3; i++) begin
      bus.rom_valid = 1'b1;
      bus.rom_inst  = 32'hDEAD_BEEF;
      tick();
      checkOutput("fault_hold_ce", {63'h0, bus.rom_ce}, 64'h0);
      checkOutput("fault_hold", {63'h0, bus.fetch_fault}, 64'h1);
      checkOutput("fault_ignore_valid", {63'h0, bus.id_valid}, 64'h0);
    end
    applyStimulus(1'b0, 32'h0, 1'b1, 64'h200, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 64'h0, 1'b0);
    checkOutput("fault_clear", {63'h0, bus.fetch_fault}, 64'h0);
    checkOutput("resume_ce", {63'h0, bus.rom_ce}, 64'h1);
    checkOutput("resume_addr", bus.rom_addr, 64'h200);
    fetchOne(64'h200, 2);
    checkOutput("resume_id_pc", bus.id_pc, 64'h200);

    $display("[TB] PC wrap at top of address space");
    applyStimulus(1'b0, 32'h0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 64'h0, 1'b1);
    fetchOne(64'hFFFF_FFFF_FFFF_FFFC, 0);
    checkOutput("wrap_id_valid", {63'h0, bus.id_valid}, 64'h1);
    checkOutput("wrap_id_pc_top", bus.id_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    fetchOne(64'h0, 0);
    checkOutput("wrap_id_pc_zero", bus.id_pc, 64'h0);
    checkOutput("wrap_id_inst", {32'h0, bus.id_inst}, {32'h0, romWord(64'h0)});
    checkOutput("wrap_no_fault", {63'h0, bus.fetch_fault}, 64'h0);

`ifdef FETCH_PERF_CNT_EN
    $display("[TB] perf counters");
    applyReset();
    bus.id_ready = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      fetchOne(64'(4 * k), 3);
    end
    checkOutput("perf_fetched", {32'h0, bus.perf_fetched}, 64'd3);
    checkOutput("perf_wait", {32'h0, bus.perf_wait}, 64'd9);
    rst = 1'b1;
    bus.rom_valid = 1'b1;
    bus.rom_inst  = romWord(64'hC);
    tick();
    rst = 1'b0;
    bus.rom_valid = 1'b0;
    checkOutput("perf_rst_ce", {63'h0, bus.rom_ce}, 64'h0);
    checkOutput("perf_rst_fetched", {32'h0, bus.perf_fetched}, 64'h0);
    checkOutput("perf_rst_wait", {32'h0, bus.perf_wait}, 64'h0);
    checkOutput("perf_rst_id_valid", {63'h0, bus.id_valid}, 64'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_fetch_ctrl.md
Name: inst_fetch_ctrl

Overview:
- Initiator side of the instruction-ROM interface: owns the PC, drives rom_ce/rom_addr, holds each request until the ROM's one-cycle rom_valid pulse, and captures rom_inst.
- Buffers fetched {pc, inst} pairs in a small FIFO.
- Delivers them to decode over a valid/ready handshake.
- Accepts redirects (branch/trap) that flush buffered and in-flight fetches.

Parameters:
RESET_PC, 64'h0, PC loaded on reset.
FIFO_DEPTH, 4, instruction buffer entries (power of two, 2..16).

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
rom_ce  out  1  request to ROM; high while a fetch is outstanding
rom_addr  out  64  byte address of the outstanding fetch (equals current PC)
rom_valid  in  1  one-cycle pulse; rom_inst valid this cycle
rom_inst  in  32  instruction word from ROM
redirect  in  1  flush and restart fetch at redirect_pc
redirect_pc  in  64  new fetch address
id_valid  out  1  FIFO head valid
id_ready  in  1  decode accepts head
id_pc  out  64  PC of head entry
id_inst  out  32  instruction of head entry
fetch_fault  out  1  misaligned redirect target; sticky until next redirect or rst
perf_fetched  out  32  fetched-instruction counter (optional feature)
perf_wait  out  32  cycles spent waiting on ROM (optional feature)

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous, active-high, sampled on the rising edge of clk.
- Reset values:
  - state=IDLE, pc=RESET_PC, FIFO empty.
  - rom_ce=0, id_valid=0, fetch_fault=0.
  - id_pc/id_inst=0, perf counters=0.
- States: IDLE, REQ, FAULT.
- Output decode:
  - rom_ce = (state==REQ).
  - rom_addr = pc in every state.
  - rom_addr is constant while rom_ce=1 until the request completes.
- IDLE:
  - -> REQ when FIFO count < FIFO_DEPTH.
  - First ce after reset: the 2nd cycle with rst=0.
- REQ, rom_valid sampled high:
  - Push {pc, rom_inst}; pc <= pc+4.
  - Stay in REQ if post-push count < FIFO_DEPTH (back-to-back fetch, next addr on the next cycle); else go to IDLE.
- REQ, rom_valid low: hold (wait cycle).
- rom_valid while not in REQ: ignored.
- Redirect, highest priority over all other events in the same cycle:
  - Flush the FIFO (id_valid=0 next cycle).
  - Discard any rom_valid/rom_inst in the same cycle.
  - If redirect_pc[1:0]==0: pc <= redirect_pc, state <= REQ (rom_ce=1, rom_addr=target on the next cycle), fetch_fault <= 0.
  - Otherwise: state <= FAULT, fetch_fault <= 1, pc <= redirect_pc.
- FAULT: rom_ce=0, no fetch; only redirect or rst leaves it.
- Decode handshake:
  - Pop when id_valid && id_ready.
  - id_pc/id_inst are stable while id_valid=1 and not popped.
  - Push and pop in the same cycle: count unchanged.
  - FIFO never overflows: a request issues only when count < FIFO_DEPTH.
- PC wrap: 64'hFFFF_FFFF_FFFF_FFFC + 4 -> 64'h0, no fault.
- Reset mid-request: rom_ce drops on the next edge and the pending response is discarded.
- Latency: rom_valid in cycle t -> id_valid=1 in cycle t+1 when the FIFO was empty (no bypass).

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined:
  - perf_fetched increments on each push.
  - perf_wait increments each cycle with state==REQ && !rom_valid.
  - Both are 32-bit, wrap at 2^32, clear on rst, and are not cleared by redirect.
- Undefined: both outputs are tied to 0 and no counter flops exist.

Decomposition:
- Package fetch_pkg:
  - State enum (IDLE/REQ/FAULT).
  - PC_W=64, INST_W=32, INST_BYTES=4.
  - Fetch-entry struct {pc, inst}.
- Sub-module fetch_fifo (synchronous FIFO of fetch entries):
  - Ports: push, pop, flush, count, head, empty.
  - Flush has priority over push/pop.
- Controller FSM and perf counters live in inst_fetch_ctrl.

Test Plan:
- Reset then free-run; ROM pulses rom_valid every 4th cycle, id_ready=1 -> rom_addr sequence 0x0,0x4,0x8; id_pc matches; id_inst equals ROM word; rom_addr stable during wait cycles.
- id_ready=0, FIFO_DEPTH=4 -> after 4 pushes state=IDLE and rom_ce=0; one pop -> rom_ce=1 next cycle at addr 0x10.
- Redirect to 0x100 in the same cycle as rom_valid with 3 entries buffered -> id_valid=0 next cycle, that word is dropped, rom_addr=0x100 next cycle, first id_pc=0x100.
- Redirect to 0x102 -> fetch_fault=1, rom_ce=0 indefinitely; redirect to 0x200 -> fault clears, fetch resumes at 0x200.
- Redirect to 0xFFFF_FFFF_FFFF_FFFC -> consecutive id_pc 0x...FFFC then 0x0.
- With FETCH_PERF_CNT_EN, 3 fetches at 3 wait cycles each -> perf_fetched=3, perf_wait=9; rst mid-request -> all zero, rom_ce=0.
